// File: rtl/parity_tx_pkg.sv
// Shared types and the parity encoder for parity_tx.
// Encoding works on a zero-extended word, so one function serves every DATA_WIDTH up to MAX_WIDTH.
package parity_tx_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic PAR_LSB = 1'b0;
    localparam logic PAR_MSB = 1'b1;

    localparam int unsigned MAX_WIDTH = 64;

    // Zero extension leaves the reduction-XOR unchanged, so parity over the full vector is exact.
    function automatic logic [MAX_WIDTH:0] encode(input logic [MAX_WIDTH-1:0] data,
                                                  input logic                 even_odd,
                                                  input logic                 parity_bit,
                                                  input int unsigned          width);
        logic               p;
        logic [MAX_WIDTH:0] word;
        p = (^data) ^ even_odd;
        if (parity_bit == PAR_LSB) begin
            word = {data, p};
        end else begin
            word = {1'b0, data} | ((MAX_WIDTH + 1)'(p) << width);
        end
        return word;
    endfunction

endpackage

// File: rtl/parity_tx.sv
// Parity-appending source stage with a 2-entry skid buffer and a wrapping delivered-word count.
// Define PARITY_TX_ERR_INJ_EN to add err_inj_i (invert parity of a pushed word) and err_cnt_o.
module parity_tx
    import parity_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned EVEN_ODD   = 0,
    parameter int unsigned PARITY_BIT = 0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  grant_o,
    input  logic                  grant_i,
    output logic [DATA_WIDTH:0]   data_o,
    output logic                  valid_o,
    output logic [1:0]            count_o,
    output logic [CNT_WIDTH-1:0]  sent_cnt_o
`ifdef PARITY_TX_ERR_INJ_EN
    ,
    input  logic                  err_inj_i,
    output logic [CNT_WIDTH-1:0]  err_cnt_o
`endif
);

    localparam logic EvenOdd   = 1'(EVEN_ODD);
    localparam logic ParityBit = 1'(PARITY_BIT);

    state_e                state_q;
    logic [DATA_WIDTH:0]   skid_q;
    logic [MAX_WIDTH-1:0]  data_ext;
    logic [DATA_WIDTH:0]   enc;
    logic                  inj;
    logic                  push;
    logic                  pop;

`ifdef PARITY_TX_ERR_INJ_EN
    assign inj = err_inj_i;
`else
    assign inj = 1'b0;
`endif

    assign push     = valid_i & grant_o;
    assign pop      = valid_o & grant_i;
    assign data_ext = MAX_WIDTH'(data_i);
    // Injection flips the parity sense, which inverts exactly the parity bit.
    assign enc      = (DATA_WIDTH + 1)'(encode(data_ext, EvenOdd ^ inj, ParityBit, DATA_WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            skid_q     <= '0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            grant_o    <= 1'b0;
            count_o    <= 2'd0;
            sent_cnt_o <= '0;
`ifdef PARITY_TX_ERR_INJ_EN
            err_cnt_o  <= '0;
`endif
        end else begin
            if (pop) begin
                sent_cnt_o <= sent_cnt_o + 1'b1;
            end
`ifdef PARITY_TX_ERR_INJ_EN
            if (push && err_inj_i) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
`endif
            unique case (state_q)
                EMPTY: begin
                    grant_o <= 1'b1;
                    if (push) begin
                        data_o  <= enc;
                        valid_o <= 1'b1;
                        count_o <= 2'd1;
                        state_q <= HALF;
                    end
                end
                HALF: begin
                    if (push && !pop) begin
                        skid_q  <= enc;
                        grant_o <= 1'b0;
                        count_o <= 2'd2;
                        state_q <= FULL;
                    end else if (push && pop) begin
                        data_o  <= enc;
                    end else if (pop) begin
                        valid_o <= 1'b0;
                        count_o <= 2'd0;
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    // grant_o is low here, so only a pop can move the state.
                    if (pop) begin
                        data_o  <= skid_q;
                        grant_o <= 1'b1;
                        count_o <= 2'd1;
                        state_q <= HALF;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_o <= 1'b0;
                    grant_o <= 1'b0;
                    count_o <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_tx.sv
// Scoreboard bench for parity_tx: drivers queue expected words, negedge monitors pop and compare.
module tb_parity_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // a: default params; b: odd parity at MSB; c: 2-bit sent counter
    logic [31:0] data_a = '0, data_b = '0, data_c = '0;
    logic        valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
    logic        gin_a = 1'b0, gin_b = 1'b0, gin_c = 1'b0;
    logic        gout_a, gout_b, gout_c;
    logic [32:0] dout_a, dout_b, dout_c;
    logic        vout_a, vout_b, vout_c;
    logic [1:0]  count_a, count_b, count_c;
    logic [15:0] sent_a, sent_b;
    logic [1:0]  sent_c;
`ifdef PARITY_TX_ERR_INJ_EN
    logic        err_inj_a = 1'b0;
    logic [15:0] err_cnt_a, err_cnt_b;
    logic [1:0]  err_cnt_c;
`endif

    int total = 0;
    int bad   = 0;
    logic [32:0] q_a[$];
    logic [32:0] q_b[$];
    logic [1:0]  sent_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    parity_tx u_dut_a (
        .clk(clk), .rst_n(rst_n), .data_i(data_a), .valid_i(valid_a), .grant_o(gout_a),
        .grant_i(gin_a), .data_o(dout_a), .valid_o(vout_a), .count_o(count_a),
        .sent_cnt_o(sent_a)
`ifdef PARITY_TX_ERR_INJ_EN
        , .err_inj_i(err_inj_a), .err_cnt_o(err_cnt_a)
`endif
    );

    parity_tx #(.EVEN_ODD(1), .PARITY_BIT(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .data_i(data_b), .valid_i(valid_b), .grant_o(gout_b),
        .grant_i(gin_b), .data_o(dout_b), .valid_o(vout_b), .count_o(count_b),
        .sent_cnt_o(sent_b)
`ifdef PARITY_TX_ERR_INJ_EN
        , .err_inj_i(1'b0), .err_cnt_o(err_cnt_b)
`endif
    );

    parity_tx #(.CNT_WIDTH(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .data_i(data_c), .valid_i(valid_c), .grant_o(gout_c),
        .grant_i(gin_c), .data_o(dout_c), .valid_o(vout_c), .count_o(count_c),
        .sent_cnt_o(sent_c)
`ifdef PARITY_TX_ERR_INJ_EN
        , .err_inj_i(1'b0), .err_cnt_o(err_cnt_c)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word is popped on the next posedge when valid and grant are both high now.
    always @(negedge clk) begin
        if (rst_n && vout_a && gin_a) begin
            if (q_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_spurious: got %0h expected no word", dout_a);
            end else begin
                check("a_data", 64'(dout_a), 64'(q_a.pop_front()));
            end
        end
        if (rst_n && vout_b && gin_b) begin
            if (q_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_spurious: got %0h expected no word", dout_b);
            end else begin
                check("b_data", 64'(dout_b), 64'(q_b.pop_front()));
            end
        end
    end

    task automatic push_a(input logic [31:0] d, input logic [32:0] exp, input logic acc);
        @(posedge clk);
        #1;
        data_a  = d;
        valid_a = 1'b1;
        @(negedge clk);
        check("a_grant_at_push", 64'(gout_a), 64'(acc));
        if (acc) q_a.push_back(exp);
    endtask

    task automatic idle_a();
        @(posedge clk);
        #1;
        valid_a = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(vout_a), 64'd0);
        check("rst_data", 64'(dout_a), 64'd0);
        check("rst_count", 64'(count_a), 64'd0);
        check("rst_grant", 64'(gout_a), 64'd0);
        check("rst_sent", 64'(sent_a), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("grant_before_edge", 64'(gout_a), 64'd0);
        @(negedge clk);
        check("grant_after_edge", 64'(gout_a), 64'd1);

        // Back-to-back with downstream always ready
        gin_a = 1'b1;
        push_a(32'h3, 33'h6, 1'b1);
        push_a(32'h1, 33'h3, 1'b1);
        idle_a();
        repeat (3) @(negedge clk);
        check("a_sent_2", 64'(sent_a), 64'd2);
        check("a_drained_1", 64'(q_a.size()), 64'd0);

        // Backpressure: third word must be refused
        gin_a = 1'b0;
        push_a(32'hA, 33'h14, 1'b1);
        push_a(32'hB, 33'h17, 1'b1);
        push_a(32'hC, 33'h18, 1'b0);
        check("a_count_full", 64'(count_a), 64'd2);
        idle_a();
        gin_a = 1'b1;
        repeat (4) @(negedge clk);
        check("a_grant_back", 64'(gout_a), 64'd1);
        check("a_sent_4", 64'(sent_a), 64'd4);
        check("a_drained_2", 64'(q_a.size()), 64'd0);
        check("a_count_empty", 64'(count_a), 64'd0);

`ifdef PARITY_TX_ERR_INJ_EN
        @(posedge clk);
        #1;
        err_inj_a = 1'b1;
        push_a(32'h3, 33'h7, 1'b1);
        idle_a();
        err_inj_a = 1'b0;
        repeat (3) @(negedge clk);
        check("a_err_cnt", 64'(err_cnt_a), 64'd1);
        check("a_sent_5", 64'(sent_a), 64'd5);
`endif

        // Odd parity placed at MSB
        gin_b = 1'b1;
        @(posedge clk);
        #1;
        data_b  = 32'h3;
        valid_b = 1'b1;
        q_b.push_back(33'h1_0000_0003);
        @(posedge clk);
        #1;
        valid_b = 1'b0;
        repeat (3) @(negedge clk);
        check("b_drained", 64'(q_b.size()), 64'd0);
        check("b_sent", 64'(sent_b), 64'd1);

        // 2-bit counter wraps
        gin_c = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            data_c  = 32'(i);
            valid_c = 1'b1;
            @(posedge clk);
            #1;
            valid_c = 1'b0;
            @(posedge clk);
            #1;
            check("c_sent_wrap", 64'(sent_c), 64'(sent_exp[i]));
        end

        // Reset while FULL discards both words
        gin_a = 1'b0;
        push_a(32'h5, 33'hA, 1'b1);
        push_a(32'h6, 33'hC, 1'b1);
        idle_a();
        #2;
        check("a_full_before_rst", 64'(count_a), 64'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(vout_a), 64'd0);
        check("mid_rst_count", 64'(count_a), 64'd0);
        check("mid_rst_data", 64'(dout_a), 64'd0);
        check("mid_rst_grant", 64'(gout_a), 64'd0);
        q_a.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        gin_a = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_valid", 64'(vout_a), 64'd0);
        check("post_rst_count", 64'(count_a), 64'd0);
        check("post_rst_sent", 64'(sent_a), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
